// File: rtl/gpioemu_mulcnt.sv
// Bus-mapped shift-add multiplier with result popcount and op counter.
// Bus strobes are edge-detected and serviced synchronously in clk domain.
module gpioemu_mulcnt #(
    parameter int          OP_W  = 24,
    parameter int          RES_W = 32,
    parameter int          CNT_W = 16,
    parameter logic [15:0] BASE  = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);

    localparam int AW = 2 * OP_W;

    typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;

    state_t             state;
    logic [OP_W-1:0]    a1;
    logic [OP_W-1:0]    a2;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      mcand;
    logic [OP_W-1:0]    mplier;
    logic [5:0]         bitcnt;
    logic [RES_W-1:0]   result;
    logic [5:0]         popcnt;
    logic               done;
    logic               valid;
    logic [CNT_W-1:0]   op_count;
    logic [31:0]        gpio_in_s;
    logic               swr_d;
    logic               srd_d;
    logic               wr_ev;
    logic               rd_ev;
    logic [31:0]        rd_data;

    function automatic logic [5:0] ones(input logic [RES_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < RES_W; i++) c = c + 6'(v[i]);
        return c;
    endfunction

    assign wr_ev          = swr & ~swr_d;
    assign rd_ev          = srd & ~srd_d;
    assign gpio_out       = 32'(op_count);
    assign gpio_in_s_insp = gpio_in_s;

    always_comb begin
        rd_data = '0;
        case (saddress)
            BASE + 16'h10: rd_data = 32'(result);
            BASE + 16'h18: rd_data = 32'(popcnt);
            BASE + 16'h20: rd_data = {30'b0, done, valid};
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            a1        <= '0;
            a2        <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            bitcnt    <= '0;
            result    <= '0;
            popcnt    <= '0;
            done      <= 1'b1;
            valid     <= 1'b1;
            op_count  <= '0;
            gpio_in_s <= '0;
            sdata_out <= '0;
            swr_d     <= 1'b0;
            srd_d     <= 1'b0;
        end else begin
            swr_d <= swr;
            srd_d <= srd;
            if (gpio_latch) gpio_in_s <= gpio_in;
            if (rd_ev) sdata_out <= rd_data;
            case (state)
                IDLE: begin
                    // Operand and start writes are only honoured while idle
                    if (wr_ev) begin
                        case (saddress)
                            BASE + 16'h00: a1 <= OP_W'(sdata_in);
                            BASE + 16'h08: a2 <= OP_W'(sdata_in);
                            BASE + 16'h20: begin
                                state  <= MULT;
                                acc    <= '0;
                                mcand  <= {{OP_W{1'b0}}, a1};
                                mplier <= a2;
                                bitcnt <= '0;
                                done   <= 1'b0;
                                valid  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    bitcnt <= bitcnt + 6'd1;
                    if (bitcnt == 6'(OP_W - 1)) state <= COUNT;
                end
                COUNT: begin
                    // Shift by the full width yields zero when nothing is cut off
                    result <= acc[RES_W-1:0];
                    valid  <= (acc >> RES_W) == '0;
                    popcnt <= ones(acc[RES_W-1:0]);
                    state  <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    op_count <= op_count + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_mulcnt.sv
// Bench for gpioemu_mulcnt: vector table, corner sequences, random ops.
// Two instances share the bus; the second has a 4-bit op counter.
module tb_gpioemu_mulcnt;

    localparam int          OP_W = 24;
    localparam logic [15:0] BASE = 16'h0380;
    localparam logic [15:0] A_A1 = BASE + 16'h00;
    localparam logic [15:0] A_A2 = BASE + 16'h08;
    localparam logic [15:0] A_RS = BASE + 16'h10;
    localparam logic [15:0] A_PC = BASE + 16'h18;
    localparam logic [15:0] A_CT = BASE + 16'h20;

    logic        clk = 0;
    logic        n_reset;
    logic [15:0] saddress;
    logic        srd, swr;
    logic [31:0] sdata_in;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] sdata_out, gpio_out, insp;
    logic [31:0] sdata_out2, gpio_out2, insp2;

    int cmp = 0;
    int bad = 0;
    int model_cnt = 0;

    gpioemu_mulcnt dut (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd),
        .swr(swr), .sdata_in(sdata_in), .sdata_out(sdata_out),
        .gpio_in(gpio_in), .gpio_latch(gpio_latch), .gpio_out(gpio_out),
        .gpio_in_s_insp(insp)
    );

    gpioemu_mulcnt #(.CNT_W(4)) dut4 (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd),
        .swr(swr), .sdata_in(sdata_in), .sdata_out(sdata_out2),
        .gpio_in(gpio_in), .gpio_latch(gpio_latch), .gpio_out(gpio_out2),
        .gpio_in_s_insp(insp2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a1;
        logic [23:0] a2;
        logic [31:0] res;
        logic [31:0] pop;
        logic [31:0] st;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        saddress = a;
        sdata_in = d;
        swr = 1;
        @(posedge clk);
        #1 swr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        saddress = a;
        srd = 1;
        @(posedge clk);
        #1 d = sdata_out;
        srd = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        logic [31:0] st;
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            bus_rd(A_CT, st);
            if (st[1]) ok = 1;
        end
        if (!ok) begin
            cmp++;
            bad++;
            $display("FAIL done_timeout: got busy expected done");
        end
    endtask

    // Reference: plain wide multiplication, no shift-add
    task automatic model(input logic [23:0] a, input logic [23:0] b,
                         output logic [31:0] r, output logic [31:0] p,
                         output logic [31:0] s);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        r = prod[31:0];
        p = 32'($countones(prod[31:0]));
        s = {30'b0, 1'b1, prod[63:32] == 0};
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input string tag, input logic [31:0] er,
                          input logic [31:0] ep, input logic [31:0] es);
        logic [31:0] d;
        bus_wr(A_A1, 32'(a));
        bus_wr(A_A2, 32'(b));
        bus_wr(A_CT, 32'h1);
        bus_rd(A_CT, d);
        check({tag, "_busy"}, d, 32'h0);
        wait_done();
        model_cnt++;
        bus_rd(A_CT, d);
        check({tag, "_status"}, d, es);
        bus_rd(A_RS, d);
        check({tag, "_result"}, d, er);
        bus_rd(A_PC, d);
        check({tag, "_popcnt"}, d, ep);
        check({tag, "_count"}, gpio_out, 32'(model_cnt));
    endtask

    initial begin
        logic [31:0] d, r, p, s;
        logic [23:0] ra, rb;

        tbl[0] = '{24'd3, 24'd5, 32'd15, 32'd4, 32'd3};
        tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 32'hFE000001, 32'd8, 32'd2};
        tbl[2] = '{24'd0, 24'd123, 32'd0, 32'd0, 32'd3};
        tbl[3] = '{24'd1, 24'hFFFFFF, 32'h00FFFFFF, 32'd24, 32'd3};
        tbl[4] = '{24'h010000, 24'h010000, 32'd0, 32'd0, 32'd2};
        tbl[5] = '{24'h000FFF, 24'h001001, 32'h00FFFFFF, 32'd24, 32'd3};

        n_reset = 0;
        saddress = 0;
        srd = 0;
        swr = 0;
        sdata_in = 0;
        gpio_in = 0;
        gpio_latch = 0;
        #12;
        check("rst_sdata_out", sdata_out, 0);
        check("rst_gpio_out", gpio_out, 0);
        @(negedge clk);
        n_reset = 1;

        bus_rd(A_CT, d);
        check("rst_status", d, 32'd3);
        bus_rd(A_RS, d);
        check("rst_result", d, 0);
        bus_rd(A_PC, d);
        check("rst_popcnt", d, 0);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a1, tbl[i].a2, $sformatf("vec%0d", i),
                   tbl[i].res, tbl[i].pop, tbl[i].st);

        // Writes and restart while busy are ignored
        bus_wr(A_A1, 32'd7);
        bus_wr(A_A2, 32'd9);
        bus_wr(A_CT, 32'h1);
        bus_wr(A_A1, 32'd100);
        bus_wr(A_CT, 32'h1);
        wait_done();
        model_cnt++;
        repeat (30) @(posedge clk);
        #1;
        check("busy_count", gpio_out, 32'(model_cnt));
        bus_rd(A_RS, d);
        check("busy_result", d, 32'd63);
        bus_wr(A_A2, 32'd1);
        bus_wr(A_CT, 32'h1);
        wait_done();
        model_cnt++;
        bus_rd(A_RS, d);
        check("a1_kept", d, 32'd7);

        // Exact latency: counter moves on edge N+OP_W+2
        bus_wr(A_A1, 32'd3);
        bus_wr(A_A2, 32'd5);
        bus_wr(A_CT, 32'h1);
        repeat (OP_W) @(posedge clk);
        #1 check("lat_before", gpio_out, 32'(model_cnt));
        @(posedge clk);
        #1 check("lat_after", gpio_out, 32'(model_cnt + 1));
        model_cnt++;

        bus_rd(BASE + 16'h28, d);
        check("unmapped_rd", d, 0);

        @(negedge clk);
        gpio_in = 32'hA5A5A5A5;
        gpio_latch = 1;
        @(negedge clk);
        gpio_latch = 0;
        gpio_in = 32'h12345678;
        repeat (3) @(posedge clk);
        #1 check("gpio_hold", insp, 32'hA5A5A5A5);

        // Asynchronous reset in the middle of MULT
        bus_wr(A_A1, 32'd5);
        bus_wr(A_A2, 32'd5);
        bus_wr(A_CT, 32'h1);
        repeat (4) @(posedge clk);
        #2 n_reset = 0;
        #1;
        check("arst_gpio_out", gpio_out, 0);
        check("arst_insp", insp, 0);
        check("arst_sdata", sdata_out, 0);
        @(negedge clk);
        n_reset = 1;
        model_cnt = 0;
        bus_rd(A_CT, d);
        check("arst_status", d, 32'd3);
        run_op(24'd2, 24'd2, "post_rst", 32'd4, 32'd1, 32'd3);

        for (int i = 0; i < 15; i++) begin
            ra = 24'($urandom);
            rb = (i % 3 == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
            model(ra, rb, r, p, s);
            run_op(ra, rb, $sformatf("rnd%0d", i), r, p, s);
        end
        check("wrap_cnt4", gpio_out2, 32'(model_cnt % 16));
        check("cnt16", gpio_out, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpioemu_mulcnt.md
Name: gpioemu_mulcnt

Overview:
- Parametrised bus-mapped arithmetic peripheral on the emulated GPIO/system bus.
- Takes two OP_W-bit operands and computes the unsigned product with an iterative shift-add multiplier, one operand bit per clock.
- Reports the low RES_W bits of the product, an overflow/valid flag, and the popcount of the reported result.
- Counts completed operations on gpio_out. Every bus access is handled synchronously in the clk domain.

Parameters:
- OP_W, 24, operand width (1..32).
- RES_W, 32, reported result width (1..32, RES_W <= 2*OP_W).
- CNT_W, 16, completed-operation counter width (1..32).
- BASE, 16'h0380, bus base address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- saddress  in  16  bus address.
- srd  in  1  read strobe (level); rising edge detected in clk domain.
- swr  in  1  write strobe (level); rising edge detected in clk domain.
- sdata_in  in  32  write data.
- sdata_out  out  32  read data.
- gpio_in  in  32  external GPIO inputs.
- gpio_latch  in  1  capture enable for gpio_in.
- gpio_out  out  32  {zero-extend, op_count[CNT_W-1:0]}.
- gpio_in_s_insp  out  32  captured gpio_in, exposed for inspection.

Behaviour:
- Reset (async assert, sync release): state=IDLE; A1=A2=0; product=0; result=0; popcnt=0; done=1; valid=1; op_count=0; gpio_in_s=0; sdata_out=0; strobe history regs=0.
- Strobe edges: swr_d/srd_d are registered copies. A write event is swr & ~swr_d; a read event is srd & ~srd_d. Holding a strobe high produces exactly one event.
- Register map:
  - BASE+0x00 A1 (W).
  - BASE+0x08 A2 (W).
  - BASE+0x10 RESULT (R): {zero, result[RES_W-1:0]}.
  - BASE+0x18 POPCNT (R): {zero, popcnt}.
  - BASE+0x20 CTRL/STATUS: write = start; read = {30'b0, done, valid}.
  - Any other address: read returns 0, write is ignored.
- Operand writes: store sdata_in[OP_W-1:0]; upper bits are dropped. Writes while busy (state != IDLE) are ignored.
- Read timing: sdata_out is registered one clk after the read event and holds its value until the next read event. Reads are allowed while busy and return current register contents.
- FSM:
  - IDLE: on a start write go to MULT. Load acc=0, mcand={OP_W'b0, A1}, mplier=A2, bitcnt=0; clear done and valid to 0.
  - MULT: each cycle, if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; bitcnt++. After OP_W cycles go to COUNT. acc is 2*OP_W bits wide and cannot wrap.
  - COUNT (1 cycle): result = acc[RES_W-1:0]; valid = (acc[2*OP_W-1:RES_W] == 0), forced to 1 when RES_W = 2*OP_W; popcnt = number of ones in acc[RES_W-1:0].
  - DONE (1 cycle): done=1; op_count++ (wraps modulo 2^CNT_W); return to IDLE.
- Latency: start event at edge N gives done=1 and final RESULT/POPCNT/STATUS visible after edge N+OP_W+2. STATUS reads 2'b00 while busy.
- Simultaneous events:
  - Start while busy is ignored; no restart and no counter change.
  - A read and a write event in the same cycle are both serviced.
  - A start in the same cycle as an operand write cannot occur (single address); the sequence A1 write then start on consecutive events uses the new A1.
- Reset mid-operation aborts the operation immediately. Results return to reset values and op_count is not incremented.
- GPIO: gpio_in_s <= gpio_in on every clk edge where gpio_latch=1; otherwise it holds. gpio_in_s_insp = gpio_in_s.

Test Plan:
- Reset, then read STATUS/RESULT/POPCNT/gpio_out -> 2'b11, 0, 0, 0.
- A1=3, A2=5, start; poll -> STATUS=2'b00 during busy; after OP_W+2 cycles RESULT=15, POPCNT=4, STATUS=2'b11, gpio_out=1.
- Defaults, A1=A2=24'hFFFFFF, start -> RESULT=32'hFE000001, POPCNT=8, STATUS=2'b10 (overflow).
- Start with A1=7, A2=9; write A1=100 and issue a second start mid-operation -> RESULT=63, gpio_out increments by exactly 1, subsequent A1 read-back path still holds 7.
- Assert n_reset during MULT -> outputs return to reset values without waiting for clk; gpio_out=0. A fresh start with A1=2, A2=2 -> RESULT=4.
- CNT_W=4: 16 back-to-back operations -> gpio_out wraps to 0. gpio_in=32'hA5A5A5A5 with gpio_latch pulsed for 1 cycle, then gpio_in changed -> gpio_in_s_insp stays 32'hA5A5A5A5.
